// File: rtl/cv32e40p_fetch_queue.sv
// OBI instruction-fetch front end: issues sequential word fetches under a credit limit,
// buffers responses in a small FIFO and flushes/redirects on a branch.
module cv32e40p_fetch_queue #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned   CW       = $clog2(DEPTH + 2);
    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_GNT_STALE
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_cnt_q;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   fifo_mem [DEPTH];

    logic [31:0]   branch_target;
    logic [31:0]   bus_addr;
    logic          bus_req;
    logic          grant;
    logic          can_req;
    logic [CW:0]   credit_used;
    logic          resp_keep;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          valid_int;
    logic [31:0]   rdata_int;
    logic          unused_inputs;

    assign unused_inputs = ^{instr_err_i, branch_addr_i[1:0]};

    assign branch_target = {branch_addr_i[31:2], 2'b00};
    assign credit_used   = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
    assign can_req       = req_i && (out_cnt_q < MAX_C) && (credit_used < {1'b0, DEPTH_C});
    assign grant         = bus_req && instr_gnt_i;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    // Request FSM: an ungranted request keeps its address on the bus even across a branch
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        bus_req      = 1'b0;
        bus_addr     = req_addr_q;
        case (state_q)
            IDLE: begin
                bus_req  = can_req;
                bus_addr = branch_i ? branch_target : fetch_addr_q;
                if (bus_req) begin
                    if (instr_gnt_i) begin
                        fetch_addr_d = bus_addr + 32'd4;
                    end else begin
                        state_d    = WAIT_GNT;
                        req_addr_d = bus_addr;
                    end
                end else if (branch_i) begin
                    fetch_addr_d = branch_target;
                end
            end
            WAIT_GNT: begin
                bus_req = 1'b1;
                if (branch_i) begin
                    fetch_addr_d = branch_target;
                    state_d      = instr_gnt_i ? IDLE : WAIT_GNT_STALE;
                end else if (instr_gnt_i) begin
                    state_d      = IDLE;
                    fetch_addr_d = req_addr_q + 32'd4;
                end
            end
            WAIT_GNT_STALE: begin
                bus_req = 1'b1;
                if (branch_i) begin
                    fetch_addr_d = branch_target;
                end
                if (instr_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // On a branch every transaction already on the bus (plus one granted now from a wait state) is stale
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (grant) begin
            out_cnt_d = out_cnt_d + CW'(1);
        end
        if (instr_rvalid_i && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_d - CW'(1);
        end
        discard_d = discard_q;
        if (branch_i) begin
            discard_d = out_cnt_q;
            if (grant && state_q != IDLE) begin
                discard_d = discard_d + CW'(1);
            end
            if (instr_rvalid_i && discard_d != '0) begin
                discard_d = discard_d - CW'(1);
            end
        end else begin
            if (grant && state_q == WAIT_GNT_STALE) begin
                discard_d = discard_d + CW'(1);
            end
            if (instr_rvalid_i && discard_q != '0) begin
                discard_d = discard_d - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            req_addr_q   <= '0;
            out_cnt_q    <= '0;
            discard_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_addr_q   <= req_addr_d;
            out_cnt_q    <= out_cnt_d;
            discard_q    <= discard_d;
        end
    end

    assign fifo_empty = (fifo_cnt_q == '0);
    assign resp_keep  = instr_rvalid_i && (discard_q == '0) && !branch_i;
    assign valid_int  = !branch_i && (!fifo_empty || resp_keep);
    assign rdata_int  = fifo_empty ? instr_rdata_i : fifo_mem[rd_ptr_q];
    assign pop        = !fifo_empty && fetch_ready_i && !branch_i;
    assign push       = resp_keep && !(fifo_empty && fetch_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (branch_i) begin
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CW'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= instr_rdata_i;
        end
    end

    // Outputs are held at zero while reset is asserted, whatever the inputs do
    assign instr_req_o   = rst_n && bus_req;
    assign instr_addr_o  = rst_n ? bus_addr : '0;
    assign fetch_valid_o = rst_n && valid_int;
    assign fetch_rdata_o = rst_n ? rdata_int : '0;
    assign busy_o        = rst_n && ((out_cnt_q != '0) || bus_req);

    always @(posedge clk) begin
        if (rst_n && instr_rvalid_i) begin
            assert (out_cnt_q != '0);
        end
        if (rst_n && push && !pop) begin
            assert (fifo_cnt_q < DEPTH_C);
        end
    end

endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// Randomised and directed bench for cv32e40p_fetch_queue; a word-addressed memory model
// checks that delivered words follow the branch target sequentially.
module tb_cv32e40p_fetch_queue;

    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;

    int req_pct = 0, gnt_pct = 0, rv_pct = 0, rdy_pct = 0, br_pct = 0;
    logic        force_br  = 1'b0;
    logic [31:0] force_tgt = '0;

    logic [31:0] bus_q[$];
    logic [31:0] exp_pc    = '0;
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = '0;
    int          delivered = 0;

    logic        last_req, last_valid, last_busy;
    logic [31:0] last_addr, last_rdata;

    cv32e40p_fetch_queue #(
        .DEPTH          (2),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .fetch_ready_i (fetch_ready_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_rdata_o (fetch_rdata_o),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .instr_err_i   (instr_err_i),
        .busy_o        (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every address maps to a distinct word, so any out-of-sequence delivery shows up
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic set_knobs(input int rq, input int gn, input int rv, input int rd, input int br);
        req_pct = rq; gnt_pct = gn; rv_pct = rv; rdy_pct = rd; br_pct = br;
    endtask

    task automatic apply_stimulus();
        logic [31:0] tgt;
        @(negedge clk);
        req_i         = ($urandom_range(99) < req_pct);
        fetch_ready_i = ($urandom_range(99) < rdy_pct);
        instr_gnt_i   = ($urandom_range(99) < gnt_pct);
        instr_err_i   = 1'($urandom_range(1));
        if (force_br) begin
            branch_i      = 1'b1;
            branch_addr_i = force_tgt;
            force_br      = 1'b0;
        end else begin
            branch_i = (br_pct > 0) && ($urandom_range(99) < br_pct);
            tgt      = $urandom;
            if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            branch_addr_i = tgt;
        end
        if (bus_q.size() != 0 && $urandom_range(99) < rv_pct) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(bus_q[0]);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
        end
        #1;
        check_output("busy", {31'b0, busy_o}, {31'b0, (bus_q.size() != 0) || instr_req_o});
        if (instr_req_o) check_output("addr_align", {30'b0, instr_addr_o[1:0]}, 32'd0);
        if (pend) begin
            check_output("req_held", {31'b0, instr_req_o}, 32'd1);
            check_output("addr_held", instr_addr_o, pend_addr);
        end
        if (branch_i) begin
            check_output("flush_valid", {31'b0, fetch_valid_o}, 32'd0);
        end else if (fetch_valid_o && fetch_ready_i) begin
            check_output("rdata_seq", fetch_rdata_o, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        last_req   = instr_req_o;
        last_addr  = instr_addr_o;
        last_valid = fetch_valid_o;
        last_rdata = fetch_rdata_o;
        last_busy  = busy_o;
        pend       = instr_req_o && !instr_gnt_i;
        pend_addr  = instr_addr_o;
        if (instr_rvalid_i) void'(bus_q.pop_front());
        if (instr_req_o && instr_gnt_i) bus_q.push_back(instr_addr_o);
        check_output("outstanding_limit", {31'b0, bus_q.size() <= MAX_OUT}, 32'd1);
        if (branch_i) exp_pc = {branch_addr_i[31:2], 2'b00};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        req_i          = 1'b1;
        branch_i       = 1'b0;
        branch_addr_i  = 32'h0000_1234;
        fetch_ready_i  = 1'b1;
        instr_gnt_i    = 1'b1;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'hDEAD_BEEF;
        instr_err_i    = 1'b0;
        #1;
        check_output("rst_req", {31'b0, instr_req_o}, 32'd0);
        check_output("rst_addr", instr_addr_o, 32'd0);
        check_output("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
        check_output("rst_rdata", fetch_rdata_o, 32'd0);
        check_output("rst_busy", {31'b0, busy_o}, 32'd0);
        bus_q.delete();
        pend   = 1'b0;
        exp_pc = '0;
        repeat (2) @(negedge clk);
        req_i       = 1'b0;
        instr_gnt_i = 1'b0;
        rst_n       = 1'b1;
    endtask

    task automatic drain();
        set_knobs(0, 100, 100, 100, 0);
        repeat (8) apply_stimulus();
        check_output("drain_busy", {31'b0, last_busy}, 32'd0);
    endtask

    task automatic branch_step(input logic [31:0] tgt);
        force_br  = 1'b1;
        force_tgt = tgt;
        apply_stimulus();
    endtask

    task automatic run_basic_stream();
        set_knobs(100, 100, 100, 100, 0);
        branch_step(32'h80);
        check_output("s1_addr0", last_addr, 32'h80);
        check_output("s1_req0", {31'b0, last_req}, 32'd1);
        check_output("s1_valid0", {31'b0, last_valid}, 32'd0);
        apply_stimulus();
        check_output("s1_addr1", last_addr, 32'h84);
        check_output("s1_valid1", {31'b0, last_valid}, 32'd1);
        check_output("s1_data1", last_rdata, mem_word(32'h80));
        apply_stimulus();
        check_output("s1_addr2", last_addr, 32'h88);
        check_output("s1_data2", last_rdata, mem_word(32'h84));
        repeat (6) apply_stimulus();
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        do_reset();
        run_basic_stream();

        // Consumer stalled: exactly DEPTH words end up buffered and requests stop
        set_knobs(100, 100, 100, 0, 0);
        repeat (8) apply_stimulus();
        check_output("s2_req_blocked", {31'b0, last_req}, 32'd0);
        check_output("s2_idle_bus", {31'b0, last_busy}, 32'd0);
        set_knobs(100, 0, 100, 100, 0);
        base = delivered;
        apply_stimulus();
        check_output("s2_no_req_before_pop", {31'b0, last_req}, 32'd0);
        repeat (3) apply_stimulus();
        check_output("s2_buffered", delivered - base, 32'd2);

        // Branch while a request waits for grant
        drain();
        set_knobs(100, 0, 100, 100, 0);
        branch_step(32'h100);
        check_output("s3_addr_first", last_addr, 32'h100);
        check_output("s3_req_first", {31'b0, last_req}, 32'd1);
        repeat (2) apply_stimulus();
        check_output("s3_addr_wait", last_addr, 32'h100);
        branch_step(32'h200);
        check_output("s3_addr_branch", last_addr, 32'h100);
        apply_stimulus();
        check_output("s3_addr_stale", last_addr, 32'h100);
        set_knobs(100, 100, 100, 100, 0);
        apply_stimulus();
        check_output("s3_addr_granted", last_addr, 32'h100);
        apply_stimulus();
        check_output("s3_addr_target", last_addr, 32'h200);
        repeat (6) apply_stimulus();

        // Branch with two transactions in flight, one answering in the branch cycle
        drain();
        set_knobs(100, 100, 0, 100, 0);
        branch_step(32'h10);
        check_output("s4_addr0", last_addr, 32'h10);
        apply_stimulus();
        check_output("s4_addr1", last_addr, 32'h14);
        set_knobs(100, 100, 100, 100, 0);
        branch_step(32'h40);
        check_output("s4_flush_valid", {31'b0, last_valid}, 32'd0);
        check_output("s4_no_credit", {31'b0, last_req}, 32'd0);
        apply_stimulus();
        check_output("s4_drop_valid", {31'b0, last_valid}, 32'd0);
        check_output("s4_addr_target", last_addr, 32'h40);
        apply_stimulus();
        check_output("s4_first_valid", {31'b0, last_valid}, 32'd1);
        check_output("s4_first_data", last_rdata, mem_word(32'h40));
        repeat (4) apply_stimulus();

        // Address wrap at the top of memory
        drain();
        set_knobs(100, 100, 100, 100, 0);
        branch_step(32'hFFFF_FFFE);
        check_output("s5_addr_top", last_addr, 32'hFFFF_FFFC);
        apply_stimulus();
        check_output("s5_addr_wrap", last_addr, 32'h0);
        check_output("s5_data_top", last_rdata, mem_word(32'hFFFF_FFFC));
        repeat (4) apply_stimulus();

        // Reset with transactions outstanding, then restart
        drain();
        set_knobs(100, 100, 0, 100, 0);
        branch_step(32'h300);
        apply_stimulus();
        check_output("s6_busy_before", {31'b0, last_busy}, 32'd1);
        do_reset();
        run_basic_stream();

        // Random traffic
        set_knobs(85, 60, 60, 70, 4);
        base = delivered;
        repeat (3000) apply_stimulus();
        drain();
        check_output("random_progress", {31'b0, (delivered - base) > 100}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
